// File: rtl/basic_if_arbiter.sv
// Two-requester round-robin arbiter for a shared basic_if with a hold timeout.
// Every output is registered; the grant is one-hot or zero.
module basic_if_arbiter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req,
    input  logic [1:0]       i_done,
    output logic [1:0]       o_gnt,
    output logic             o_owner,
    output logic             o_busy,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_grant_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic win;
    logic own_release;
    logic hold_expired;

    // On a tie the requester that did not own the bus most recently wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last_owner);
        if (req == 2'b11) begin
            return ~last_owner;
        end
        return req[1];
    endfunction

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        busy_d       = busy_q;
        timeout_d    = 1'b0;
        grant_cnt_d  = grant_cnt_q;
        hold_d       = hold_q;
        win          = pick_winner(i_req, owner_q);
        own_release  = i_done[owner_q] || !i_req[owner_q];
        hold_expired = (hold_q == HOLD_LAST);

        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                gnt_d  = 2'b00;
                busy_d = 1'b0;
                if (|i_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    owner_d = win;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    if (grant_cnt_q != '1) begin
                        grant_cnt_d = grant_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (own_release || hold_expired) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = 2'b00;
                    busy_d    = 1'b0;
                    // A coincident done/drop is a normal release, not a timeout.
                    timeout_d = hold_expired && !own_release;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 2'b00;
            owner_q     <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            grant_cnt_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            grant_cnt_q <= grant_cnt_d;
            hold_q      <= hold_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_owner     = owner_q;
    assign o_busy      = busy_q;
    assign o_timeout   = timeout_q;
    assign o_grant_cnt = grant_cnt_q;

endmodule
